// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - Y86-64 SEQ decode and write-back stage with 15x64 register file
//
// Decodes source/destination register IDs from icode/rA/rB, reads operands
// combinationally and writes valE/valM back on the rising clock edge.
// ID 4'hF means "no register": it reads as zero and is never written.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   icode, rA, rB               instruction fields from fetch
//   cnd                         execute condition, gates cmovXX write
//   hlt, ins_address,
//   adr_address                 fetch exception flags, any one blocks write-back
//   valE, valM                  execute and memory results to write back
//   srcA, srcB, dstE, dstM      decoded register IDs
//   valA, valB                  operands read from the register file
//   wb_count                    cycles with at least one register written
//
// Optional feature: define REGFILE_BYPASS_EN to forward this cycle's
// write data onto valA/valB when the read ID matches an active write.

module decode_writeback (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  icode,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic        cnd,
   input  logic        hlt,
   input  logic        ins_address,
   input  logic        adr_address,
   input  logic [63:0] valE,
   input  logic [63:0] valM,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   output logic [3:0]  dstE,
   output logic [3:0]  dstM,
   output logic [63:0] valA,
   output logic [63:0] valB,
   output logic [31:0] wb_count
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'h4;

   logic [63:0] regs [0:14];
   logic        we;
   logic        wr_e;
   logic        wr_m;

   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         4'h2: begin                         // rrmovq / cmovXX
            srcA = rA;
            dstE = cnd ? rB : RNONE;
         end
         4'h3: dstE = rB;                    // irmovq
         4'h4: begin                         // rmmovq
            srcA = rA;
            srcB = rB;
         end
         4'h5: begin                         // mrmovq
            srcB = rB;
            dstM = rA;
         end
         4'h6: begin                         // OPq
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         4'h8: begin                         // call
            srcB = RSP;
            dstE = RSP;
         end
         4'h9: begin                         // ret
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
         end
         4'hA: begin                         // pushq
            srcA = rA;
            srcB = RSP;
            dstE = RSP;
         end
         4'hB: begin                         // popq
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
            dstM = rA;
         end
         default: ;
      endcase
   end

   assign we   = ~(hlt | ins_address | adr_address);
   assign wr_e = we && (dstE != RNONE);
   assign wr_m = we && (dstM != RNONE);

   always_comb begin
      valA = (srcA == RNONE) ? 64'h0 : regs[srcA];
      valB = (srcB == RNONE) ? 64'h0 : regs[srcB];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is held off during reset so operands still read zero.
      // wr_e/wr_m already exclude ID 4'hF, so no separate check is needed.
      if (!rst && wr_m && (dstM == srcA))      valA = valM;
      else if (!rst && wr_e && (dstE == srcA)) valA = valE;
      if (!rst && wr_m && (dstM == srcB))      valB = valM;
      else if (!rst && wr_e && (dstE == srcB)) valB = valE;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) regs[i] <= 64'h0;
         wb_count <= 32'h0;
      end else begin
         // The valM write comes last so it wins when dstE == dstM (popq %rsp).
         if (wr_e) regs[dstE] <= valE;
         if (wr_m) regs[dstM] <= valM;
         if (wr_e || wr_m) wb_count <= wb_count + 32'h1;
      end
   end

endmodule
